rtc_adj_ctrl: RTL and testbench
===============================

Name: rtc_adj_ctrl

Overview:
Controller that sequences all configuration writes into the rtc time accumulator. It arbitrates three requesters: a ToD step, a period (frequency) update and an offset slew. A slew is a signed time correction that the controller breaks into bounded chunks, each applied once through the rtc adj_ld/period_adj mechanism. The block sits between the servo/CPU register logic and rtc, and drives every rtc load input.

Parameters:
MAX_CHUNK, 128, maximum magnitude of one slew chunk, in 2^-8 ns units (default 0.5 ns); legal range 1..32767.
SPACING, 15, value driven on adj_ld_data; rtc fires its adjustment SPACING cycles after adj_ld.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ts_valid  in  1  ToD step request
ts_ready  out  1  always 1 (combinational)
ts_ns  in  38  ns[37:8] and fraction[7:0] to load
ts_sec  in  48  seconds to load
per_valid  in  1  period update request
per_ready  out  1  = !ts_valid (combinational)
per_val  in  40  new period, 8.32 ns format
slw_valid  in  1  slew request
slw_ready  out  1  = (state==IDLE) & !ts_valid & !per_valid (combinational)
slw_off  in  32  signed offset, 2^-8 ns units
slw_busy  out  1  high while a slew is in progress
slw_done  out  1  one-cycle pulse when a slew has completed
slw_abort  out  1  one-cycle pulse when a ToD step killed a slew
time_ld  out  1  to rtc
time_reg_ns_in  out  38  to rtc
time_reg_sec_in  out  48  to rtc
period_ld  out  1  to rtc
period_in  out  40  to rtc
adj_ld  out  1  to rtc
adj_ld_data  out  32  to rtc
period_adj  out  40  to rtc

Behaviour:
- Reset: every registered output is 0 except adj_ld_data, which resets to SPACING. State resets to IDLE and the residue to 0.
- A transfer happens on valid & ready at a clk edge. The controller samples the data in that cycle. The matching rtc strobe is registered and asserts for exactly one cycle on the next cycle. The data outputs hold their last value.
- Priority: ts > per > slw start. A ToD step and a period update never issue in the same cycle; when both are presented, the period update goes one cycle after the ToD step.
- A period update is accepted in any state and does not disturb a slew in progress.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: on a slw transfer, rem (33-bit signed) <= sext(slw_off), then go to ISSUE.
- ISSUE:
  - chunk = clamp(rem, -MAX_CHUNK, +MAX_CHUNK).
  - If rem==0: pulse slw_done and go to IDLE. A zero offset therefore produces no adj_ld.
  - Else: adj_ld <= 1 for one cycle; period_adj <= sext40(chunk) << 24; rem <= rem - chunk; wcnt <= SPACING+3; go to WAIT.
- WAIT: decrement wcnt each cycle. At wcnt==0, go to ISSUE. period_adj holds its value throughout WAIT.
- On slw_done, period_adj <= 0 in the same cycle.
- slw_busy = (state != IDLE).
- Number of adj_ld pulses = ceil(|slw_off| / MAX_CHUNK). Spacing between adj_ld pulses = SPACING+5 cycles.
- A ts transfer while state != IDLE:
  - state -> IDLE, rem <= 0, period_adj <= 0;
  - slw_abort pulses on the cycle time_ld asserts;
  - slw_done does not pulse.
  - The partially applied correction is left in place.
- A ts transfer in ISSUE wins over the chunk issue: no adj_ld is issued that cycle.
- Arithmetic: period_adj is two's-complement in 40-bit wrap arithmetic (rtc adds it modulo 2^40). slw_off = -2^31 must be handled without overflow (33-bit rem).
- Reset mid-slew returns to the reset values immediately; no done or abort pulse is generated.

Decomposition:
- Package rtc_ctrl_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - width constants NS_W=38, SEC_W=48, PER_W=40, OFF_W=32;
  - a clamp function.
- No sub-module; the single module is roughly 200 lines.

Test Plan:
- Reset -> all outputs 0, adj_ld_data=15, slw_ready=1, slw_busy=0.
- ts_valid with ts_ns=0x3B9AC9F00, ts_sec=5 -> time_ld pulses one cycle later with those values on time_reg_ns_in/time_reg_sec_in. Present ts and per in the same cycle -> period_ld asserts one cycle after time_ld.
- slw_off=+0x300, MAX_CHUNK=0x80 -> 6 adj_ld pulses spaced 20 cycles apart, each with period_adj=0x0080000000. Then slw_done; period_adj returns to 0.
- slw_off=-0x90 -> 2 pulses with period_adj=0xFF80000000, then 0xFFF0000000. Then slw_done.
- slw_off=0 -> slw_done two cycles after acceptance, with no adj_ld.
- Mid-slew ts step, after 2 of 6 chunks -> slw_abort and time_ld on the same cycle, state returns to IDLE, period_adj=0, no further adj_ld. With rtc attached, the time advance equals 2 chunks.

Source files
------------

// File: rtl/rtc_ctrl_pkg.sv
// Shared types and widths for the rtc adjustment controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int NS_W  = 38;
  localparam int SEC_W = 48;
  localparam int PER_W = 40;
  localparam int OFF_W = 32;
  // One extra bit so that negating -2^31 cannot overflow.
  localparam int REM_W = OFF_W + 1;

  // Saturate v into [-lim, +lim].
  function automatic logic signed [REM_W-1:0] clamp(
    input logic signed [REM_W-1:0] v,
    input logic signed [REM_W-1:0] lim
  );
    logic signed [REM_W-1:0] r;
    r = v;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end
    clamp = r;
  endfunction

endpackage

// File: rtl/rtc_adj_ctrl.sv
// Sequences ToD steps, period updates and chunked offset slews into the rtc load inputs.
// Latency: every rtc strobe is registered, one cycle after its valid&ready transfer.
// Backpressure: ts always accepted; per stalls behind ts; slew start needs idle and no ts/per.
module rtc_adj_ctrl
  import rtc_ctrl_pkg::*;
#(
  parameter int MAX_CHUNK = 128,
  parameter int SPACING   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ts_valid,
  output logic             ts_ready,
  input  logic [NS_W-1:0]  ts_ns,
  input  logic [SEC_W-1:0] ts_sec,
  input  logic             per_valid,
  output logic             per_ready,
  input  logic [PER_W-1:0] per_val,
  input  logic             slw_valid,
  output logic             slw_ready,
  input  logic [OFF_W-1:0] slw_off,
  output logic             slw_busy,
  output logic             slw_done,
  output logic             slw_abort,
  output logic             time_ld,
  output logic [NS_W-1:0]  time_reg_ns_in,
  output logic [SEC_W-1:0] time_reg_sec_in,
  output logic             period_ld,
  output logic [PER_W-1:0] period_in,
  output logic             adj_ld,
  output logic [31:0]      adj_ld_data,
  output logic [PER_W-1:0] period_adj
);

  localparam int WCNT_W = $clog2(SPACING + 4);
  localparam logic signed [REM_W-1:0] LIM       = REM_W'(MAX_CHUNK);
  localparam logic [WCNT_W-1:0]       WCNT_INIT = WCNT_W'(SPACING + 3);

  state_e                  state_q, state_d;
  logic signed [REM_W-1:0] rem_q, rem_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    time_ld_q, time_ld_d;
  logic [NS_W-1:0]         time_ns_q, time_ns_d;
  logic [SEC_W-1:0]        time_sec_q, time_sec_d;
  logic                    period_ld_q, period_ld_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic                    adj_ld_q, adj_ld_d;
  logic [PER_W-1:0]        padj_q, padj_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic                    ts_xfer, per_xfer, slw_xfer;
  logic signed [REM_W-1:0] chunk;
  logic [PER_W-1:0]        chunk40;

  // Priority ts > per > slew start: lower requesters are held off combinationally.
  assign ts_ready  = 1'b1;
  assign per_ready = !ts_valid;
  assign slw_ready = (state_q == IDLE) && !ts_valid && !per_valid;

  assign ts_xfer  = ts_valid && ts_ready;
  assign per_xfer = per_valid && per_ready;
  assign slw_xfer = slw_valid && slw_ready;

  assign chunk   = clamp(rem_q, LIM);
  assign chunk40 = {{(PER_W - REM_W){chunk[REM_W-1]}}, chunk};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a ToD step always kills an active slew back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slw_xfer) state_d = ISSUE;
      ISSUE:   if (ts_xfer || rem_q == '0) state_d = IDLE;
               else state_d = WAIT;
      WAIT:    if (ts_xfer) state_d = IDLE;
               else if (wcnt_q == '0) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values: strobes default low, data holds.
  always_comb begin
    time_ld_d   = ts_xfer;
    time_ns_d   = ts_xfer ? ts_ns : time_ns_q;
    time_sec_d  = ts_xfer ? ts_sec : time_sec_q;
    period_ld_d = per_xfer;
    period_d    = per_xfer ? per_val : period_q;
    rem_d       = rem_q;
    wcnt_d      = wcnt_q;
    adj_ld_d    = 1'b0;
    padj_d      = padj_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (slw_xfer) rem_d = {slw_off[OFF_W-1], slw_off};
      end
      ISSUE: begin
        if (ts_xfer) begin
          rem_d   = '0;
          padj_d  = '0;
          abort_d = 1'b1;
        end else if (rem_q == '0) begin
          done_d = 1'b1;
          padj_d = '0;
        end else begin
          adj_ld_d = 1'b1;
          padj_d   = chunk40 << 24;
          rem_d    = rem_q - chunk;
          wcnt_d   = WCNT_INIT;
        end
      end
      WAIT: begin
        if (ts_xfer) begin
          rem_d   = '0;
          padj_d  = '0;
          abort_d = 1'b1;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      wcnt_q      <= '0;
      time_ld_q   <= 1'b0;
      time_ns_q   <= '0;
      time_sec_q  <= '0;
      period_ld_q <= 1'b0;
      period_q    <= '0;
      adj_ld_q    <= 1'b0;
      padj_q      <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      wcnt_q      <= wcnt_d;
      time_ld_q   <= time_ld_d;
      time_ns_q   <= time_ns_d;
      time_sec_q  <= time_sec_d;
      period_ld_q <= period_ld_d;
      period_q    <= period_d;
      adj_ld_q    <= adj_ld_d;
      padj_q      <= padj_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign slw_busy        = (state_q != IDLE);
  assign slw_done        = done_q;
  assign slw_abort       = abort_q;
  assign time_ld         = time_ld_q;
  assign time_reg_ns_in  = time_ns_q;
  assign time_reg_sec_in = time_sec_q;
  assign period_ld       = period_ld_q;
  assign period_in       = period_q;
  assign adj_ld          = adj_ld_q;
  assign adj_ld_data     = 32'(SPACING);
  assign period_adj      = padj_q;

endmodule

// File: tb/tb_rtc_adj_ctrl.sv
// Self-checking bench for rtc_adj_ctrl: schedule-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_adj_ctrl;

  localparam int     MAXC = 128;
  localparam int     SPC  = 15;
  localparam longint GAP  = SPC + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ts_valid = 1'b0, per_valid = 1'b0, slw_valid = 1'b0;
  logic [37:0] ts_ns = '0;
  logic [47:0] ts_sec = '0;
  logic [39:0] per_val = '0;
  logic [31:0] slw_off = '0;
  logic        ts_ready, per_ready, slw_ready, slw_busy, slw_done, slw_abort;
  logic        time_ld, period_ld, adj_ld;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic [39:0] period_in, period_adj;
  logic [31:0] adj_ld_data;

  always #5 clk = ~clk;

  rtc_adj_ctrl #(.MAX_CHUNK(MAXC), .SPACING(SPC)) dut (
    .clk(clk), .rst(rst),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_ns(ts_ns), .ts_sec(ts_sec),
    .per_valid(per_valid), .per_ready(per_ready), .per_val(per_val),
    .slw_valid(slw_valid), .slw_ready(slw_ready), .slw_off(slw_off),
    .slw_busy(slw_busy), .slw_done(slw_done), .slw_abort(slw_abort),
    .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
    .period_ld(period_ld), .period_in(period_in),
    .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .period_adj(period_adj)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A slew accepted in cycle sc with offset so is a fixed schedule: chunk k appears on
  // adj_ld at cycle sc+2+GAP*k for k < sn, done at sc+2+GAP*sn; busy spans sc+1..sc+1+GAP*sn.
  longint t = 0;
  bit     sl_live = 1'b0;
  longint sc = 0, sn = 0, absn = 0;
  logic signed [31:0] so = '0;
  logic        e_time_ld = 0, e_per_ld = 0, e_adj = 0, e_done = 0, e_abort = 0;
  logic [37:0] e_ns = '0;
  logic [47:0] e_sec = '0;
  logic [39:0] e_per = '0, e_padj = '0;

  function automatic bit model_busy(input longint x);
    return sl_live && (x >= sc + 1) && (x <= sc + 1 + GAP * sn);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        {e_time_ld, e_per_ld, e_adj, e_done, e_abort} = '0;
        e_ns = '0; e_sec = '0; e_per = '0; e_padj = '0;
        sl_live = 1'b0;
      end else begin
        bit busy_now, ts_x, per_x, acc;
        longint x, k, mag, ch, pa;
        busy_now = model_busy(t);
        ts_x  = ts_valid;
        per_x = per_valid && !ts_valid;
        acc   = slw_valid && !busy_now && !ts_valid && !per_valid;
        e_time_ld = ts_x;
        if (ts_x) begin e_ns = ts_ns; e_sec = ts_sec; end
        e_per_ld = per_x;
        if (per_x) e_per = per_val;
        e_adj = 0; e_done = 0; e_abort = 0;
        if (ts_x && busy_now) begin
          e_abort = 1; sl_live = 0; e_padj = '0;
        end
        if (acc) begin
          sl_live = 1; sc = t; so = slw_off;
          absn = (so < 0) ? -longint'(so) : longint'(so);
          sn = (absn + MAXC - 1) / MAXC;
        end
        x = t + 1;
        if (sl_live && x >= sc + 2 && ((x - sc - 2) % GAP) == 0) begin
          k = (x - sc - 2) / GAP;
          if (k < sn) begin
            mag = absn - k * MAXC;
            if (mag > MAXC) mag = MAXC;
            ch = (so < 0) ? -mag : mag;
            pa = ch * 64'sd16777216;
            e_adj = 1; e_padj = pa[39:0];
          end else begin
            e_done = 1; e_padj = '0; sl_live = 0;
          end
        end
      end
      t++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("time_ld", time_ld, e_time_ld);
        check("time_ns", time_reg_ns_in, e_ns);
        check("time_sec", time_reg_sec_in, e_sec);
        check("period_ld", period_ld, e_per_ld);
        check("period_in", period_in, e_per);
        check("adj_ld", adj_ld, e_adj);
        check("period_adj", period_adj, e_padj);
        check("slw_done", slw_done, e_done);
        check("slw_abort", slw_abort, e_abort);
        check("slw_busy", slw_busy, model_busy(t));
        check("slw_ready", slw_ready, !model_busy(t) && !ts_valid && !per_valid);
        check("per_ready", per_ready, !ts_valid);
        check("ts_ready", ts_ready, 1);
        check("adj_ld_data", adj_ld_data, SPC);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [39:0] pv_q[$];
  int          gap_q[$];
  int          done_at;
  logic [39:0] done_padj;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a slew and record adj_ld values, pulse gaps and the done cycle (relative to acceptance).
  task automatic run_slew(input logic [31:0] off);
    int last;
    pv_q.delete(); gap_q.delete();
    done_at = -1; done_padj = '1; last = -1;
    slw_valid = 1'b1; slw_off = off;
    tick();
    slw_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (adj_ld) begin
        pv_q.push_back(period_adj);
        if (last >= 0) gap_q.push_back(n - last);
        last = n;
      end
      if (slw_done) begin
        done_at = n; done_padj = period_adj;
        break;
      end
      tick();
    end
    tick();
  endtask

  function automatic logic [31:0] pick_off();
    int v;
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7fff_ffff;
      3: return ($urandom % 2) ? 32'd128 : 32'hffff_ff80;
      4: return ($urandom % 2) ? 32'd129 : 32'hffff_ff7f;
      5: return ($urandom % 2) ? 32'd1 : 32'hffff_ffff;
      default: begin
        v = int'($urandom_range(0, 1500));
        return ($urandom % 2) ? 32'(v) : 32'(-v);
      end
    endcase
  endfunction

  initial begin
    int np, nadj, ndone;
    longint sum;
    repeat (3) tick();
    // reset state
    check("rst_adj_ld_data", adj_ld_data, 32'd15);
    check("rst_period_adj", period_adj, 40'h0);
    check("rst_time_ld", time_ld, 0);
    check("rst_slw_ready", slw_ready, 1);
    check("rst_slw_busy", slw_busy, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // ToD step and period update presented together
    ts_valid = 1; ts_ns = 38'h3B9AC9F00; ts_sec = 48'd5;
    per_valid = 1; per_val = 40'h12_3456_789A;
    tick();
    ts_valid = 0;
    check("ts_time_ld", time_ld, 1);
    check("ts_ns_val", time_reg_ns_in, 38'h3B9AC9F00);
    check("ts_sec_val", time_reg_sec_in, 48'd5);
    check("per_not_yet", period_ld, 0);
    tick();
    per_valid = 0;
    check("per_ld_after", period_ld, 1);
    check("per_in_val", period_in, 40'h12_3456_789A);
    check("ts_ld_gone", time_ld, 0);
    tick();

    // +0x300: six full chunks, 20 cycles apart
    run_slew(32'h300);
    check("p300_count", pv_q.size(), 6);
    foreach (pv_q[i]) check("p300_val", pv_q[i], 40'h00_8000_0000);
    foreach (gap_q[i]) check("p300_gap", gap_q[i], 20);
    check("p300_done_at", done_at, 122);
    check("p300_padj_zero", done_padj, 40'h0);

    // -0x90: full negative chunk then remainder
    run_slew(32'hffff_ff70);
    check("m90_count", pv_q.size(), 2);
    if (pv_q.size() == 2) begin
      check("m90_val0", pv_q[0], 40'hFF_8000_0000);
      check("m90_val1", pv_q[1], 40'hFF_F000_0000);
    end
    check("m90_done_at", done_at, 42);

    // zero offset: done without any adj_ld
    run_slew(32'h0);
    check("zero_count", pv_q.size(), 0);
    check("zero_done_at", done_at, 2);

    // ToD step after two of six chunks
    slw_valid = 1; slw_off = 32'h300;
    tick();
    slw_valid = 0;
    np = 0; sum = 0;
    for (int i = 0; i < 200 && np < 2; i++) begin
      if (adj_ld) begin np++; sum += longint'($signed(period_adj)); end
      tick();
    end
    check("abort_two_chunks", np, 2);
    check("abort_sum", sum, 64'h1_0000_0000);
    repeat (5) tick();
    ts_valid = 1; ts_ns = 38'h12345; ts_sec = 48'd7;
    tick();
    ts_valid = 0;
    check("abort_pulse", slw_abort, 1);
    check("abort_time_ld", time_ld, 1);
    check("abort_padj", period_adj, 40'h0);
    check("abort_busy", slw_busy, 0);
    nadj = 0; ndone = 0;
    for (int i = 0; i < 100; i++) begin
      if (adj_ld) nadj++;
      if (slw_done) ndone++;
      tick();
    end
    check("abort_no_adj", nadj, 0);
    check("abort_no_done", ndone, 0);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      ts_valid  = ($urandom % 50) == 0;
      ts_ns     = 38'({$urandom, $urandom});
      ts_sec    = 48'({$urandom, $urandom});
      per_valid = ($urandom % 10) == 0;
      per_val   = 40'({$urandom, $urandom});
      slw_valid = ($urandom % 3) == 0;
      slw_off   = pick_off();
      if (i == 3000) begin
        chk_en = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("midrst_busy", slw_busy, 0);
        check("midrst_padj", period_adj, 40'h0);
        check("midrst_done", slw_done, 0);
        check("midrst_abort", slw_abort, 0);
        rst = 1'b0;
        chk_en = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
